rx_psdu_packer: RTL and testbench
=================================

Name: rx_psdu_packer

Overview:
- Sits directly downstream of the serial descrambler in the 802.11a RX chain.
- Consumes descrambled bits and discards the remaining SERVICE bits; the descrambler has already absorbed the first 7 as seed.
- Packs PSDU bits LSB-first into bytes, counts exactly LENGTH bytes, then drops tail/pad bits.
- Emits a byte stream with first/last markers to the MAC-side buffer.

Parameters:
- SERVICE_BITS, 9, descrambled SERVICE bits to strip before PSDU data (16 minus 7 seed bits).
- LEN_W, 12, width of the PSDU length in bytes (802.11a max 4095).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches psdu_len and arms a frame
- psdu_len  in  LEN_W  PSDU length in bytes (from SIGNAL field)
- bit_in  in  1  descrambled bit
- bit_valid  in  1  bit_in qualifier
- byte_out  out  8  assembled PSDU byte
- byte_valid  out  1  one-cycle strobe per byte
- byte_first  out  1  with byte_valid on byte 0
- byte_last  out  1  with byte_valid on byte psdu_len-1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse, same cycle as byte_last
- len_err  out  1  one-cycle pulse when start is given with psdu_len==0
- service_err  out  1  sticky per frame: any stripped SERVICE bit was 1 (reserved bits must be 0)
- fcs_valid  out  1  see Optional Feature
- fcs_ok  out  1  see Optional Feature

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, shift register 0.

States:
- IDLE: bit_valid ignored.
  - start with psdu_len!=0: latch length, clear service_err, go to SERVICE.
  - start with psdu_len==0: pulse len_err next cycle, stay IDLE.
- SERVICE: each bit_valid increments svc_cnt; any bit_in==1 sets service_err. On the SERVICE_BITS-th bit go to DATA.
- DATA: each bit_valid shifts shreg={bit_in,shreg[7:1]}, so the first bit lands in byte bit 0.
  - On the 8th bit: byte_out, byte_valid, and byte_first/byte_last are registered and appear the cycle after that bit is sampled (latency 1).
  - byte_cnt then increments.
  - After byte psdu_len-1: done pulse with byte_last, return to IDLE. Remaining tail/pad bits arrive in IDLE and are ignored.
- psdu_len==1: byte_first and byte_last both assert on the same strobe.

Counters and outputs:
- byte_cnt is LEN_W bits wide, compared against latched length - 1; no wrap is possible.
- byte_out holds its last value between strobes; byte_valid is never asserted outside DATA.

Edge cases:
- start while busy: abort the current frame and restart with the new length. No byte_last or done is issued for the aborted frame. A partial byte is discarded.
- start and bit_valid in the same cycle: that bit is not counted.
- bit_valid gaps of any length are permitted; the count advances only on bit_valid.
- reset mid-frame: immediate return to IDLE; no done is issued.

Optional Feature:
Macro RX_PSDU_FCS_CHECK_EN.
- With the macro:
  - A CRC-32 (802.3 polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over every PSDU byte, including the 4 FCS bytes.
  - On the cycle after done: fcs_valid pulses, and fcs_ok=1 iff the residue equals 0xDEBB20E3 (un-complemented register).
  - psdu_len<4: fcs_ok=0.
- Without the macro: CRC logic is absent; fcs_valid and fcs_ok are tied 0; ports are retained.

Decomposition:
- Package wlan_rx_pkg holds:
  - the state encoding (IDLE, SERVICE, DATA)
  - SERVICE_BITS default
  - CRC32_POLY, CRC32_INIT, CRC32_RESIDUE constants
- One sub-module: rx_crc32_byte. It is a byte-wide combinational next-CRC plus a register with clear/enable, and is instantiated only under the macro.

Test Plan:
- start, psdu_len=2, 9 zero SERVICE bits, then bits for 0xA5, 0x3C sent LSB-first, then 6 pad bits -> two strobes:
  - byte_out=0xA5 with byte_first=1
  - byte_out=0x3C with byte_last=1 and done=1
  - service_err=0, busy low afterwards, pad ignored.
- SERVICE bit 4 =1, psdu_len=1, data 0xFF -> service_err=1; one strobe 0xFF with byte_first=byte_last=done=1.
- start with psdu_len=0 -> len_err pulse; busy stays 0; subsequent bits produce no byte_valid.
- psdu_len=3, second start pulse after 1 byte plus 3 bits -> no done for the first frame; the new frame strips 9 SERVICE bits again, then outputs a fresh byte_first.
- bit_valid toggled every 3rd cycle with random gaps, psdu_len=4 -> identical byte values, each strobe exactly 1 cycle after the 8th valid bit.
- (RX_PSDU_FCS_CHECK_EN) PSDU "123456789" plus FCS 0xCBF43926 sent LE (26 39 F4 CB), psdu_len=13 -> fcs_valid with fcs_ok=1. Flipping one data bit -> fcs_ok=0.

Source files
------------

// File: rtl/rx_psdu_packer_pkg.sv
// Shared types and constants for the 802.11a RX PSDU packer and its CRC-32 checker.
// State encoding, default geometry, and the 802.3 CRC-32 constants live here.
package wlan_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVICE = 2'd1,
        DATA    = 2'd2
    } rx_state_t;

    // 16 SERVICE bits minus the 7 the descrambler consumed as its seed
    localparam int SERVICE_BITS_DEF = 9;
    localparam int LEN_W_DEF        = 12;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_psdu_packer_if.sv
// Bit-in / byte-out stream bundle between descrambler, packer and MAC-side buffer.
// The master drives bits and receives bytes; the packer is the slave.
interface rx_psdu_packer_if;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_first;
    logic       byte_last;

    modport master (
        output bit_in, bit_valid,
        input  byte_out, byte_valid, byte_first, byte_last
    );

    modport slave (
        input  bit_in, bit_valid,
        output byte_out, byte_valid, byte_first, byte_last
    );
endinterface

// File: rtl/rx_crc32_byte.sv
// Reflected CRC-32 accumulator consuming one byte per enabled cycle.
// clr reloads the init value; the register is not complemented on output.
module rx_crc32_byte
    import wlan_rx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

    logic [31:0] crc_reg;
    logic [31:0] stage [0:8];

    assign stage[0] = crc_reg ^ {24'd0, data};

    // One LSB-first polynomial step per data bit, unrolled across the byte
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign stage[gi+1] = stage[gi][0] ? ((stage[gi] >> 1) ^ POLY_REFL)
                                              :  (stage[gi] >> 1);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            crc_reg <= CRC32_INIT;
        end else if (en) begin
            crc_reg <= stage[8];
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/rx_psdu_packer.sv
// Strips residual SERVICE bits, packs PSDU bits LSB-first into LENGTH bytes, drops tail/pad.
// Define RX_PSDU_FCS_CHECK_EN to add the CRC-32 FCS residue check on fcs_valid/fcs_ok.
module rx_psdu_packer
    import wlan_rx_pkg::*;
#(
    parameter int SERVICE_BITS = SERVICE_BITS_DEF,
    parameter int LEN_W        = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  psdu_len,
    rx_psdu_packer_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    output logic              service_err,
    output logic              fcs_valid,
    output logic              fcs_ok
);

    localparam int SVC_W = (SERVICE_BITS > 1) ? $clog2(SERVICE_BITS) : 1;
    localparam logic [SVC_W-1:0] SVC_LAST = SVC_W'(SERVICE_BITS - 1);

    rx_state_t          state_reg, state_next;
    logic [SVC_W-1:0]   svc_cnt_reg, svc_cnt_next;
    logic [2:0]         bit_cnt_reg, bit_cnt_next;
    logic [7:0]         shreg_reg, shreg_next;
    logic [LEN_W-1:0]   byte_cnt_reg, byte_cnt_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [7:0]         byte_out_reg, byte_out_next;
    logic               byte_valid_reg, byte_valid_next;
    logic               byte_first_reg, byte_first_next;
    logic               byte_last_reg, byte_last_next;
    logic               done_reg, done_next;
    logic               len_err_reg, len_err_next;
    logic               service_err_reg, service_err_next;

    logic [7:0]         shift_in;
    logic               last_byte;

    assign shift_in  = {bus.bit_in, shreg_reg[7:1]};
    assign last_byte = (byte_cnt_reg == (len_reg - LEN_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            svc_cnt_reg     <= '0;
            bit_cnt_reg     <= '0;
            shreg_reg       <= '0;
            byte_cnt_reg    <= '0;
            len_reg         <= '0;
            byte_out_reg    <= '0;
            byte_valid_reg  <= 1'b0;
            byte_first_reg  <= 1'b0;
            byte_last_reg   <= 1'b0;
            done_reg        <= 1'b0;
            len_err_reg     <= 1'b0;
            service_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            svc_cnt_reg     <= svc_cnt_next;
            bit_cnt_reg     <= bit_cnt_next;
            shreg_reg       <= shreg_next;
            byte_cnt_reg    <= byte_cnt_next;
            len_reg         <= len_next;
            byte_out_reg    <= byte_out_next;
            byte_valid_reg  <= byte_valid_next;
            byte_first_reg  <= byte_first_next;
            byte_last_reg   <= byte_last_next;
            done_reg        <= done_next;
            len_err_reg     <= len_err_next;
            service_err_reg <= service_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        svc_cnt_next     = svc_cnt_reg;
        bit_cnt_next     = bit_cnt_reg;
        shreg_next       = shreg_reg;
        byte_cnt_next    = byte_cnt_reg;
        len_next         = len_reg;
        byte_out_next    = byte_out_reg;
        byte_valid_next  = 1'b0;
        byte_first_next  = 1'b0;
        byte_last_next   = 1'b0;
        done_next        = 1'b0;
        len_err_next     = 1'b0;
        service_err_next = service_err_reg;

        // start wins over any bit in the same cycle and aborts a frame in flight
        if (start) begin
            if (psdu_len == '0) begin
                len_err_next = 1'b1;
                state_next   = IDLE;
            end else begin
                state_next       = SERVICE;
                len_next         = psdu_len;
                service_err_next = 1'b0;
                svc_cnt_next     = '0;
                bit_cnt_next     = '0;
                shreg_next       = '0;
                byte_cnt_next    = '0;
            end
        end else begin
            case (state_reg)
                SERVICE: begin
                    if (bus.bit_valid) begin
                        if (bus.bit_in) begin
                            service_err_next = 1'b1;
                        end
                        if (svc_cnt_reg == SVC_LAST) begin
                            svc_cnt_next = '0;
                            state_next   = DATA;
                        end else begin
                            svc_cnt_next = svc_cnt_reg + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (bus.bit_valid) begin
                        shreg_next   = shift_in;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            byte_out_next   = shift_in;
                            byte_valid_next = 1'b1;
                            byte_first_next = (byte_cnt_reg == '0);
                            if (last_byte) begin
                                byte_last_next = 1'b1;
                                done_next      = 1'b1;
                                state_next     = IDLE;
                            end else begin
                                byte_cnt_next = byte_cnt_reg + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_out   = byte_out_reg;
    assign bus.byte_valid = byte_valid_reg;
    assign bus.byte_first = byte_first_reg;
    assign bus.byte_last  = byte_last_reg;
    assign busy           = (state_reg != IDLE);
    assign done           = done_reg;
    assign len_err        = len_err_reg;
    assign service_err    = service_err_reg;

`ifdef RX_PSDU_FCS_CHECK_EN
    logic        crc_clr;
    logic        crc_en;
    logic [31:0] crc_value;
    logic        fcs_valid_reg;
    logic        fcs_ok_reg;

    assign crc_clr = start && (psdu_len != '0);
    assign crc_en  = !start && (state_reg == DATA) && bus.bit_valid && (bit_cnt_reg == 3'd7);

    rx_crc32_byte u_crc (
        .clk   (clk),
        .reset (reset),
        .clr   (crc_clr),
        .en    (crc_en),
        .data  (shift_in),
        .crc   (crc_value)
    );

    // Sampled in the done cycle, when the register already holds the final residue
    always_ff @(posedge clk) begin
        if (reset) begin
            fcs_valid_reg <= 1'b0;
            fcs_ok_reg    <= 1'b0;
        end else begin
            fcs_valid_reg <= done_reg;
            fcs_ok_reg    <= done_reg && (len_reg >= LEN_W'(4)) && (crc_value == CRC32_RESIDUE);
        end
    end

    assign fcs_valid = fcs_valid_reg;
    assign fcs_ok    = fcs_ok_reg;
`else
    assign fcs_valid = 1'b0;
    assign fcs_ok    = 1'b0;
`endif

endmodule

// File: tb/tb_rx_psdu_packer.sv
// Self-checking bench for rx_psdu_packer: randomized bit streams vs. a byte-level frame model.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge or 1 unit after posedge.
module tb_rx_psdu_packer;

    localparam int LEN_W = 12;
    localparam int SVC   = 9;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] psdu_len = '0;
    logic             busy, done, len_err, service_err, fcs_valid, fcs_ok;

    rx_psdu_packer_if bus ();

    rx_psdu_packer #(.SERVICE_BITS(SVC), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .psdu_len    (psdu_len),
        .bus         (bus.slave),
        .busy        (busy),
        .done        (done),
        .len_err     (len_err),
        .service_err (service_err),
        .fcs_valid   (fcs_valid),
        .fcs_ok      (fcs_ok)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        logic [7:0] data;
        logic       first;
        logic       last;
        logic       fin;
    } strobe_t;

    strobe_t obs_q[$];
    strobe_t exp_q[$];
    int      fcs_cyc_q[$];
    logic    fcs_ok_q[$];
    int      pcyc = 0;
    int      len_err_cnt = 0;
    int      fcs_any_cnt = 0;
    int      vectors = 0;
    int      miscompares = 0;

    always @(posedge clk) pcyc <= pcyc + 1;

    // Monitor: every strobe or done pulse, tagged with the cycle it was seen
    always @(negedge clk) begin
        if (bus.byte_valid || done)
            obs_q.push_back('{pcyc, bus.byte_out, bus.byte_first, bus.byte_last, done});
        if (len_err) len_err_cnt <= len_err_cnt + 1;
        if (fcs_valid || fcs_ok) fcs_any_cnt <= fcs_any_cnt + 1;
        if (fcs_valid) begin
            fcs_cyc_q.push_back(pcyc);
            fcs_ok_q.push_back(fcs_ok);
        end
    end

    task automatic drive(input logic s, input int l, input logic b, input logic v);
        @(posedge clk); #1;
        start         = s;
        psdu_len      = LEN_W'(l);
        bus.bit_in    = b;
        bus.bit_valid = v;
    endtask

    task automatic gap(input int gap_max);
        repeat ($urandom_range(gap_max)) drive(1'b0, 0, 1'($urandom), 1'b0);
    endtask

    // Sends one frame and records the strobes the model expects: byte i appears
    // one cycle after its 8th bit is sampled, only for i < len.
    task automatic send_frame(input int len, input logic [SVC-1:0] svc, input logic [7:0] data[$],
                              input int extra, input int pad, input int gap_max, input bit start_bv);
        drive(1'b1, len, 1'b1, start_bv);
        for (int i = 0; i < SVC; i++) begin
            gap(gap_max);
            drive(1'b0, 0, svc[i], 1'b1);
        end
        for (int i = 0; i < data.size(); i++) begin
            for (int b = 0; b < 8; b++) begin
                gap(gap_max);
                drive(1'b0, 0, data[i][b], 1'b1);
                if (b == 7 && i < len)
                    exp_q.push_back('{pcyc + 1, data[i], i == 0, i == len - 1, i == len - 1});
            end
        end
        for (int i = 0; i < extra; i++) begin
            gap(gap_max);
            drive(1'b0, 0, 1'($urandom), 1'b1);
        end
        for (int i = 0; i < pad; i++) drive(1'b0, 0, 1'($urandom), 1'b1);
        drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.byte_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_byte_out: got %02h want 00", bus.byte_out);
        end
        vectors++;
        if ({bus.byte_valid, bus.byte_first, bus.byte_last} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 000", {bus.byte_valid, bus.byte_first, bus.byte_last});
        end
        vectors++;
        if ({busy, done, len_err, service_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_status: got %b want 0000", {busy, done, len_err, service_err});
        end
        vectors++;
        if ({fcs_valid, fcs_ok} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_fcs: got %b want 00", {fcs_valid, fcs_ok});
        end
        reset = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        obs_q.delete(); exp_q.delete();
        send_frame(2, '0, {8'hA5, 8'h3C}, 0, 6, 0, 1'b0);
        repeat (3) drive(1'b0, 0, 1'b0, 1'b0);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL basic_count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL basic_strobe%0d: got cyc=%0d byte=%02h fld=%b%b%b want cyc=%0d byte=%02h fld=%b%b%b", i,
                         obs_q[i].cyc, obs_q[i].data, obs_q[i].first, obs_q[i].last, obs_q[i].fin,
                         exp_q[i].cyc, exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].fin);
            end
        end
        vectors++;
        if ({service_err, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_status: got service_err,busy=%b want 00", {service_err, busy});
        end
        vectors++;
        if (bus.byte_out !== 8'h3C) begin
            miscompares++;
            $display("FAIL basic_hold: got %02h want 3c", bus.byte_out);
        end
        $display("test_basic: %0d strobes observed", obs_q.size());
    endtask

    task automatic test_service_err();
        obs_q.delete(); exp_q.delete();
        send_frame(1, 9'b0_0001_0000, {8'hFF}, 0, 4, 0, 1'b0);
        repeat (2) drive(1'b0, 0, 1'b0, 1'b0);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++;
            $display("FAIL svc_count: got %0d strobes want 1", obs_q.size());
        end else begin
            vectors++;
            if (obs_q[0] !== exp_q[0]) begin
                miscompares++;
                $display("FAIL svc_strobe: got cyc=%0d byte=%02h fld=%b%b%b want cyc=%0d byte=ff fld=111",
                         obs_q[0].cyc, obs_q[0].data, obs_q[0].first, obs_q[0].last, obs_q[0].fin, exp_q[0].cyc);
            end
        end
        vectors++;
        if (service_err !== 1'b1) begin
            miscompares++;
            $display("FAIL svc_err: got %b want 1", service_err);
        end
        $display("test_service_err: service_err=%b", service_err);
    endtask

    task automatic test_len_zero();
        int base;
        obs_q.delete();
        base = len_err_cnt;
        drive(1'b1, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        vectors++;
        if ({len_err, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL lenzero_pulse: got len_err,busy=%b want 10", {len_err, busy});
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        vectors++;
        if (len_err !== 1'b0) begin
            miscompares++;
            $display("FAIL lenzero_width: got len_err=%b want 0", len_err);
        end
        repeat (24) drive(1'b0, 0, 1'($urandom), 1'b1);
        drive(1'b0, 0, 1'b0, 1'b0);
        vectors++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL lenzero_idle: got %0d strobes busy=%b want 0 strobes busy=0", obs_q.size(), busy);
        end
        vectors++;
        if (len_err_cnt - base != 1) begin
            miscompares++;
            $display("FAIL lenzero_count: got %0d pulses want 1", len_err_cnt - base);
        end
        $display("test_len_zero: len_err pulses=%0d", len_err_cnt - base);
    endtask

    task automatic test_abort();
        logic [7:0] d1, c0, c1;
        obs_q.delete(); exp_q.delete();
        d1 = 8'($urandom); c0 = 8'($urandom); c1 = 8'($urandom);
        send_frame(3, '0, {d1}, 3, 0, 0, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_busy: got %b want 1", busy);
        end
        send_frame(2, '0, {c0, c1}, 0, 4, 1, 1'b0);
        repeat (2) drive(1'b0, 0, 1'b0, 1'b0);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL abort_count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL abort_strobe%0d: got cyc=%0d byte=%02h fld=%b%b%b want cyc=%0d byte=%02h fld=%b%b%b", i,
                         obs_q[i].cyc, obs_q[i].data, obs_q[i].first, obs_q[i].last, obs_q[i].fin,
                         exp_q[i].cyc, exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].fin);
            end
        end
        $display("test_abort: %0d strobes observed", obs_q.size());
    endtask

    task automatic test_gaps();
        logic [7:0] d[$];
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) d.push_back(8'($urandom));
        send_frame(4, '0, d, 0, 5, 4, 1'b1);
        repeat (2) drive(1'b0, 0, 1'b0, 1'b0);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL gaps_count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL gaps_strobe%0d: got cyc=%0d byte=%02h fld=%b%b%b want cyc=%0d byte=%02h fld=%b%b%b", i,
                         obs_q[i].cyc, obs_q[i].data, obs_q[i].first, obs_q[i].last, obs_q[i].fin,
                         exp_q[i].cyc, exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].fin);
            end
        end
        $display("test_gaps: %0d strobes observed", obs_q.size());
    endtask

    task automatic test_back_to_back();
        logic [7:0]     d[$];
        logic [SVC-1:0] svc;
        int             len;
        obs_q.delete(); exp_q.delete();
        for (int f = 0; f < 6; f++) begin
            d.delete();
            len = $urandom_range(6, 1);
            svc = ($urandom_range(2) == 0) ? SVC'($urandom) : '0;
            for (int i = 0; i < len; i++) d.push_back(8'($urandom));
            send_frame(len, svc, d, 0, $urandom_range(7), 1, 1'($urandom));
            vectors++;
            if (service_err !== (|svc) || bus.byte_out !== d[len-1]) begin
                miscompares++;
                $display("FAIL b2b_frame%0d: got service_err=%b byte_out=%02h want %b %02h",
                         f, service_err, bus.byte_out, |svc, d[len-1]);
            end
        end
        repeat (2) drive(1'b0, 0, 1'b0, 1'b0);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL b2b_strobe%0d: got cyc=%0d byte=%02h fld=%b%b%b want cyc=%0d byte=%02h fld=%b%b%b", i,
                         obs_q[i].cyc, obs_q[i].data, obs_q[i].first, obs_q[i].last, obs_q[i].fin,
                         exp_q[i].cyc, exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].fin);
            end
        end
        $display("test_back_to_back: %0d strobes observed", obs_q.size());
    endtask

    task automatic test_reset_midframe();
        logic [7:0] x;
        obs_q.delete(); exp_q.delete();
        x = 8'($urandom);
        send_frame(5, '1, {8'($urandom)}, 2, 0, 0, 1'b0);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({busy, service_err, bus.byte_valid, done, bus.byte_out} !== 12'h000) begin
            miscompares++;
            $display("FAIL midreset_state: got busy,serr,bv,done=%b byte=%02h want 0000 00",
                     {busy, service_err, bus.byte_valid, done}, bus.byte_out);
        end
        reset = 1'b0;
        send_frame(1, '0, {x}, 0, 3, 0, 1'b0);
        repeat (2) drive(1'b0, 0, 1'b0, 1'b0);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL midreset_count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL midreset_strobe%0d: got cyc=%0d byte=%02h fld=%b%b%b want cyc=%0d byte=%02h fld=%b%b%b", i,
                         obs_q[i].cyc, obs_q[i].data, obs_q[i].first, obs_q[i].last, obs_q[i].fin,
                         exp_q[i].cyc, exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].fin);
            end
        end
        $display("test_reset_midframe: %0d strobes observed", obs_q.size());
    endtask

`ifdef RX_PSDU_FCS_CHECK_EN
    task automatic test_fcs();
        logic [7:0] good[$];
        logic [7:0] bad[$];
        good = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
        bad  = good;
        bad[0] = 8'h30;
        for (int k = 0; k < 3; k++) begin
            obs_q.delete(); exp_q.delete(); fcs_cyc_q.delete(); fcs_ok_q.delete();
            if (k == 0) send_frame(13, '0, good, 0, 2, 0, 1'b0);
            else if (k == 1) send_frame(13, '0, bad, 0, 2, 0, 1'b0);
            else send_frame(2, '0, {8'h00, 8'h00}, 0, 2, 0, 1'b0);
            repeat (3) drive(1'b0, 0, 1'b0, 1'b0);
            vectors++;
            if (fcs_cyc_q.size() != 1 || exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL fcs%0d_count: got %0d fcs_valid pulses want 1", k, fcs_cyc_q.size());
            end else begin
                vectors++;
                if (fcs_cyc_q[0] != exp_q[exp_q.size()-1].cyc + 1 || fcs_ok_q[0] !== (k == 0)) begin
                    miscompares++;
                    $display("FAIL fcs%0d_result: got cyc=%0d ok=%b want cyc=%0d ok=%b", k,
                             fcs_cyc_q[0], fcs_ok_q[0], exp_q[exp_q.size()-1].cyc + 1, k == 0);
                end
            end
        end
        $display("test_fcs: done");
    endtask
`else
    task automatic test_fcs();
        vectors++;
        if (fcs_any_cnt != 0) begin
            miscompares++;
            $display("FAIL fcs_absent: got %0d cycles with fcs outputs high want 0", fcs_any_cnt);
        end
        $display("test_fcs: fcs outputs tied low");
    endtask
`endif

    initial begin
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        test_reset();
        test_basic();
        test_service_err();
        test_len_zero();
        test_abort();
        test_gaps();
        test_back_to_back();
        test_reset_midframe();
        test_fcs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
